alu_hs: RTL
===========

Name: alu_hs

Overview:
- Parametrised, handshaked successor to the team's 4-bit registered ALU.
- Operand width is generic. Operation set extended to 4-bit opcodes, including a multi-cycle shift-add multiply.
- Produces status flags. Uses valid/ready on both input and output, so it can sit between a register-file read stage and a writeback stage with backpressure.

Parameters:
- WIDTH, 8, operand and result width in bits (>=2).
- MUL_EN, 1, 1 = opcode MUL implemented; 0 = MUL treated as reserved.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand/opcode presented
- in_ready  out  1  block can accept a new operation this cycle
- rd_reg1  in  WIDTH  operand A
- rd_reg2  in  WIDTH  operand B
- alu_op  in  4  opcode
- out_valid  out  1  result registers hold a valid result
- out_ready  in  1  downstream consumes result this cycle
- alu_output  out  WIDTH  result
- flag_zero  out  1  alu_output == 0
- flag_carry  out  1  carry/borrow/overflow-high-part indicator
- flag_err  out  1  reserved opcode was executed

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
  - rst sampled high at a clk edge: state=IDLE, out_valid=0, alu_output=0, all flags=0, multiplier registers cleared.
  - rst overrides any in-flight operation, including MUL mid-iteration. The aborted result is never presented.
- Acceptance: in_ready = (state==IDLE) && (!out_valid || out_ready). An op is accepted on an edge where in_valid && in_ready.
- Opcodes, all unsigned, result truncated to WIDTH:
  - 0 ADD: A+B, carry = bit WIDTH of the sum.
  - 1 SUB: A-B, carry = borrow (A<B).
  - 2 NOT: ~A.
  - 3 SHR: A>>1, carry = A[0].
  - 4 SHL: A<<1, carry = A[WIDTH-1].
  - 5 GT: 1 if A>B else 0.
  - 6 EQ: 1 if A==B else 0.
  - 7 STORE: B.
  - 8 LOAD: A.
  - 9 AND, 10 OR, 11 XOR.
  - 12 MUL: low WIDTH bits of A*B, carry = (high WIDTH bits != 0).
  - 13-15 reserved: result 0, flag_err=1.
- Carry is 0 for every op not listed with a carry definition. flag_zero is computed from the registered result.
- Single-cycle ops (all except MUL):
  - Result, flags and out_valid=1 are registered on the accepting edge.
  - Latency is 1 cycle; throughput is 1 op/cycle when out_ready is held high.
- MUL (MUL_EN=1):
  - On accept: go to state MUL, latch A and B, acc=0, count=0, out_valid cleared on the same edge.
  - Each cycle in MUL: if B_shift[0], acc += A_shift (2*WIDTH-bit accumulator); then A_shift<<=1, B_shift>>=1, count++.
  - After WIDTH iterations: register the result and flags, out_valid=1, state=IDLE.
  - out_valid rises exactly WIDTH+1 edges after the accepting edge, counting the accepting edge. in_ready=0 throughout MUL.
- MUL_EN=0: opcode 12 behaves as reserved.
- Output hold: while out_valid && !out_ready, alu_output and the flags are stable and no new op is accepted.
- Output drain: out_valid clears on an edge with out_ready=1 unless a new op completes on that same edge.
- Simultaneous consume + accept: the new single-cycle result replaces the old one; out_valid stays 1.
- States: IDLE, MUL. Unused encodings return to IDLE.

Test Plan (WIDTH=8, MUL_EN=1):
- Reset mid-MUL: accept MUL A=3 B=5, assert rst on 3rd cycle -> next cycle out_valid=0, alu_output=0, in_ready=1, no result ever appears.
- Back-to-back with out_ready=1: ADD 200+100, SUB 5-7, SHL 0x81 on consecutive cycles.
  - ADD -> 44 (0x2C), carry=1.
  - SUB -> 0xFE, carry=1.
  - SHL -> 0x02, carry=1.
  - One result per cycle, each 1 cycle after accept.
- Compare/pass ops:
  - GT 9,9 -> 0 with zero=1; EQ 9,9 -> 1 with zero=0.
  - STORE A=1,B=0xAA -> 0xAA; LOAD -> 0x01.
  - NOT 0x0F -> 0xF0.
- Multiply:
  - MUL 13*11 -> 143 (0x8F), carry=0; out_valid 9 edges after accept, in_ready=0 during.
  - MUL 0xFF*2 -> 0xFE, carry=1.
- Backpressure: hold out_ready=0 after ADD 1+1 -> alu_output=2 stable, in_ready=0 for 5 cycles. Raise out_ready with in_valid ADD 3+4 -> same edge drains and loads 7, out_valid stays 1.
- Reserved opcode 14 -> alu_output=0, flag_err=1, zero=1. Next ADD clears flag_err.

Source files
------------

// File: rtl/alu_hs.sv
// rtl/alu_hs.sv - handshaked parametrised ALU with multi-cycle shift-add multiply
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid, in_ready   operation handshake (rd_reg1 = A, rd_reg2 = B, alu_op)
//   out_valid, out_ready result handshake
//   alu_output           registered result
//   flag_zero            registered result == 0
//   flag_carry           carry / borrow / shifted-out bit / MUL high half non-zero
//   flag_err             reserved opcode executed
module alu_hs #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rd_reg1,
  input  logic [WIDTH-1:0] rd_reg2,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_output,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]   res_q, res_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
  logic               err_q, err_d;
  logic               valid_q, valid_d;
  logic [2*WIDTH-1:0] a_sh_q, a_sh_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               accept;
  logic               is_mul;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   op_res;
  logic               op_carry;
  logic               op_err;
  logic [2*WIDTH-1:0] acc_nxt;

  // A pending result blocks acceptance unless it is drained on the same edge.
  assign in_ready = (state_q == S_IDLE) && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = MUL_EN && (alu_op == 4'd12);

  assign sum  = {1'b0, rd_reg1} + {1'b0, rd_reg2};
  // The extra top bit of the difference is the borrow (A < B).
  assign diff = {1'b0, rd_reg1} - {1'b0, rd_reg2};

  assign acc_nxt = acc_q + (b_sh_q[0] ? a_sh_q : '0);

  // Single-cycle datapath; opcode 12 falls into the reserved arm when MUL_EN=0.
  always_comb begin
    op_res   = '0;
    op_carry = 1'b0;
    op_err   = 1'b0;
    case (alu_op)
      4'd0:  begin op_res = sum[WIDTH-1:0];  op_carry = sum[WIDTH];  end
      4'd1:  begin op_res = diff[WIDTH-1:0]; op_carry = diff[WIDTH]; end
      4'd2:  op_res = ~rd_reg1;
      4'd3:  begin op_res = rd_reg1 >> 1; op_carry = rd_reg1[0]; end
      4'd4:  begin op_res = rd_reg1 << 1; op_carry = rd_reg1[WIDTH-1]; end
      4'd5:  op_res = {{(WIDTH-1){1'b0}}, (rd_reg1 > rd_reg2)};
      4'd6:  op_res = {{(WIDTH-1){1'b0}}, (rd_reg1 == rd_reg2)};
      4'd7:  op_res = rd_reg2;
      4'd8:  op_res = rd_reg1;
      4'd9:  op_res = rd_reg1 & rd_reg2;
      4'd10: op_res = rd_reg1 | rd_reg2;
      4'd11: op_res = rd_reg1 ^ rd_reg2;
      default: op_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    err_d   = err_q;
    valid_d = valid_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (valid_q && out_ready) valid_d = 1'b0;
        if (accept) begin
          if (is_mul) begin
            state_d = S_MUL;
            a_sh_d  = {{WIDTH{1'b0}}, rd_reg1};
            b_sh_d  = rd_reg2;
            acc_d   = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
          end else begin
            res_d   = op_res;
            zero_d  = (op_res == '0);
            carry_d = op_carry;
            err_d   = op_err;
            valid_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d  = acc_nxt;
        a_sh_d = a_sh_q << 1;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        // Last iteration: publish the product straight from the adder output.
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_IDLE;
          res_d   = acc_nxt[WIDTH-1:0];
          zero_d  = (acc_nxt[WIDTH-1:0] == '0);
          carry_d = |acc_nxt[2*WIDTH-1:WIDTH];
          err_d   = 1'b0;
          valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid  = valid_q;
  assign alu_output = res_q;
  assign flag_zero  = zero_q;
  assign flag_carry = carry_q;
  assign flag_err   = err_q;

endmodule
